// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the Wishbone many-to-one arbiter.
//   arb_state_e : arbiter FSM state encoding
//   cnt_width() : width of a counter able to hold 0..max_val
package wb_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_select.sv
// Rotating-priority requester scan.
// Finds the first asserted req bit scanning upward from last+1 and wrapping
// modulo Count.
//   req  : request vector, one bit per master
//   last : index of the most recently granted master
//   any  : at least one request present
//   idx  : selected master index (0 when any=0)
module wb_arbiter_rr_select #(
  parameter int Count    = 2,
  parameter int TagWidth = $clog2(Count)
) (
  input  logic [Count-1:0]    req,
  input  logic [TagWidth-1:0] last,
  output logic                any,
  output logic [TagWidth-1:0] idx
);

  // Walk the offsets from farthest to nearest so the nearest requester
  // after last is the one left standing.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = Count; k >= 1; k--) begin
      if (req[(int'(last) + k) % Count]) begin
        any = 1'b1;
        idx = TagWidth'((int'(last) + k) % Count);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Many-to-one pipelined Wishbone arbiter. Count masters share one slave port
// under round-robin arbitration; a grant is held for the whole bus cycle and
// until every accepted strobe has been answered.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   m_data_m/m_addr/m_sel         master write data, address, byte selects
//   m_cyc/m_stb/m_we              master cycle, strobe, write enable
//   m_data_s                      read data broadcast to every master
//   m_ack/m_err/m_stall           per-master response and flow control
//   s_data_m/s_addr/s_sel         slave-side request data, address, selects
//   s_cyc/s_stb/s_we              slave-side cycle, strobe, write enable
//   s_data_s/s_ack/s_err/s_stall  slave response and flow control
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no owner; slave port quiet, every master stalled
// ARB_BUSY | master grant_q owns the slave port until cyc low and drained
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int Count          = 2,
  parameter  int DataWidth      = 32,
  parameter  int AddrWidth      = 32,
  parameter  int MaxOutstanding = 7,
  localparam int SelWidth       = DataWidth / 8,
  localparam int TagWidth       = $clog2(Count)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [Count-1:0][DataWidth-1:0]  m_data_m,
  input  logic [Count-1:0][AddrWidth-1:0]  m_addr,
  input  logic [Count-1:0][SelWidth-1:0]   m_sel,
  input  logic [Count-1:0]                 m_cyc,
  input  logic [Count-1:0]                 m_stb,
  input  logic [Count-1:0]                 m_we,
  output logic [Count-1:0][DataWidth-1:0]  m_data_s,
  output logic [Count-1:0]                 m_ack,
  output logic [Count-1:0]                 m_err,
  output logic [Count-1:0]                 m_stall,
  output logic [DataWidth-1:0]             s_data_m,
  output logic [AddrWidth-1:0]             s_addr,
  output logic [SelWidth-1:0]              s_sel,
  output logic                             s_cyc,
  output logic                             s_stb,
  output logic                             s_we,
  input  logic [DataWidth-1:0]             s_data_s,
  input  logic                             s_ack,
  input  logic                             s_err,
  input  logic                             s_stall
);

  localparam int CntWidth = cnt_width(MaxOutstanding);

  arb_state_e          state_q, state_d;
  logic [TagWidth-1:0] grant_q, grant_d;
  logic [TagWidth-1:0] last_q, last_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic                sel_any;
  logic [TagWidth-1:0] sel_idx;
  logic                full;
  logic                cnt_inc;
  logic                cnt_dec;

  wb_arbiter_rr_select #(
    .Count    (Count),
    .TagWidth (TagWidth)
  ) u_rr_select (
    .req  (m_cyc),
    .last (last_q),
    .any  (sel_any),
    .idx  (sel_idx)
  );

  assign full = (count_q == CntWidth'(MaxOutstanding));

  // Request payload simply follows the current grant; it is only
  // meaningful while s_cyc/s_stb are asserted.
  assign s_data_m = m_data_m[grant_q];
  assign s_addr   = m_addr[grant_q];
  assign s_sel    = m_sel[grant_q];
  assign s_we     = m_we[grant_q];

  // Masters qualify read data with their own ack.
  assign m_data_s = {Count{s_data_s}};

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_stall = '1;
    m_ack   = '0;
    m_err   = '0;
    if (state_q == ARB_BUSY) begin
      // Cycle stays up while responses are pending even if the owner let go.
      s_cyc            = m_cyc[grant_q] | (count_q != '0);
      s_stb            = m_stb[grant_q] & ~full;
      m_stall[grant_q] = s_stall | full;
      m_ack[grant_q]   = s_ack;
      m_err[grant_q]   = s_err;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (sel_any) begin
          state_d = ARB_BUSY;
          grant_d = sel_idx;
          last_d  = sel_idx;
        end
      end
      ARB_BUSY: begin
        cnt_inc = s_stb & ~s_stall;
        // A response with nothing outstanding is ignored by the counter.
        cnt_dec = (s_ack | s_err) & (count_q != '0);
        if (s_err) begin
          count_d = '0;
        end else if (cnt_inc & ~cnt_dec) begin
          count_d = count_q + CntWidth'(1);
        end else if (cnt_dec & ~cnt_inc) begin
          count_d = count_q - CntWidth'(1);
        end
        // Release goes through IDLE so a new owner is never granted on the
        // same edge.
        if (!m_cyc[grant_q] && (count_d == '0)) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= TagWidth'(Count - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level owner/pending model.
module tb_wb_arbiter;

  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXO = 7;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0][DW-1:0]  m_data_m;
  logic [N-1:0][AW-1:0]  m_addr;
  logic [N-1:0][SW-1:0]  m_sel;
  logic [N-1:0]          m_cyc, m_stb, m_we;
  logic [N-1:0][DW-1:0]  m_data_s;
  logic [N-1:0]          m_ack, m_err, m_stall;
  logic [DW-1:0]         s_data_m;
  logic [AW-1:0]         s_addr;
  logic [SW-1:0]         s_sel;
  logic                  s_cyc, s_stb, s_we;
  logic [DW-1:0]         s_data_s;
  logic                  s_ack, s_err, s_stall;

  wb_arbiter #(
    .Count          (N),
    .DataWidth      (DW),
    .AddrWidth      (AW),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_data_m (m_data_m),
    .m_addr   (m_addr),
    .m_sel    (m_sel),
    .m_cyc    (m_cyc),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_data_s (m_data_s),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_stall  (m_stall),
    .s_data_m (s_data_m),
    .s_addr   (s_addr),
    .s_sel    (s_sel),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_data_s (s_data_s),
    .s_ack    (s_ack),
    .s_err    (s_err),
    .s_stall  (s_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus (-1 = nobody), who was served last,
  // and how many accepted strobes are still unanswered.
  int own;
  int last;
  int pend;

  logic         e_scyc, e_sstb;
  logic [N-1:0] e_stall, e_ack, e_err;
  logic [N-1:0] acc_vec;

  // Random master behaviour
  logic [N-1:0] act;
  int           left [N];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic calc_exp();
    e_scyc  = 1'b0;
    e_sstb  = 1'b0;
    e_stall = '1;
    e_ack   = '0;
    e_err   = '0;
    if (own >= 0) begin
      e_scyc       = m_cyc[own] || (pend > 0);
      e_sstb       = m_stb[own] && (pend != MAXO);
      e_stall[own] = s_stall || (pend == MAXO);
      e_ack[own]   = s_ack;
      e_err[own]   = s_err;
    end
    acc_vec = m_stb & ~e_stall;
  endtask

  task automatic model_update();
    int inc, dec;
    if (reset) begin
      own  = -1;
      last = N - 1;
      pend = 0;
    end else if (own < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_cyc[(last + k) % N]) begin
          own  = (last + k) % N;
          last = own;
          break;
        end
      end
    end else begin
      if (s_err) begin
        pend = 0;
      end else begin
        inc  = (e_sstb && !s_stall) ? 1 : 0;
        dec  = (s_ack && pend > 0) ? 1 : 0;
        pend = pend + inc - dec;
      end
      if (!m_cyc[own] && pend == 0) own = -1;
    end
  endtask

  // Called just after a rising edge with this cycle's inputs already driven.
  task automatic step();
    #2;
    calc_exp();
    check_val("s_cyc", s_cyc, e_scyc);
    check_val("s_stb", s_stb, e_sstb);
    check_val("m_stall", m_stall, e_stall);
    check_val("m_ack", m_ack, e_ack);
    check_val("m_err", m_err, e_err);
    check_val("m_data_s", m_data_s, {N{s_data_s}});
    if (own >= 0) begin
      check_val("s_addr", s_addr, m_addr[own]);
      check_val("s_data_m", s_data_m, m_data_m[own]);
      check_val("s_sel", s_sel, m_sel[own]);
      check_val("s_we", s_we, m_we[own]);
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc   = '0;
    m_stb   = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    m_data_m = '0;
    m_sel    = '0;
    m_we     = '0;
    s_data_s = 32'hDEAD_BEEF;
    for (int i = 0; i < N; i++) m_addr[i] = AW'(32'h1000 * (i + 1));
    idle_inputs();
    own  = -1;
    last = N - 1;
    pend = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Lone requester on master 1
    do_reset();
    m_addr[1] = 32'h100;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    check_val("t1_scyc", s_cyc, 1'b1);
    check_val("t1_saddr", s_addr, 32'h100);
    check_val("t1_stall0", m_stall[0], 1'b1);
    step();
    m_stb[1] = 1'b0; m_cyc[1] = 1'b0; s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    step();
    check_val("t1_rel", s_cyc, 1'b0);

    // Simultaneous requests: 0 first, idle gap, then 1
    do_reset();
    m_addr[1] = 32'h200;
    m_cyc = 3'b011;
    step();
    check_val("t2_own0", m_stall[0], 1'b0);
    check_val("t2_stall1", m_stall[1], 1'b1);
    m_cyc = 3'b010;
    step();
    check_val("t2_gap_cyc", s_cyc, 1'b0);
    check_val("t2_gap_stall", m_stall, 3'b111);
    step();
    check_val("t2_own1", m_stall[1], 1'b0);
    check_val("t2_addr1", s_addr, 32'h200);
    m_cyc = '0;
    step();
    step();

    // Three strobes, acks two cycles later, cyc dropped early
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    step();
    step();
    s_ack = 1'b1;
    step();
    m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
    step();
    check_val("t3_hold", s_cyc, 1'b1);
    step();
    s_ack = 1'b0;
    check_val("t3_drop", s_cyc, 1'b0);
    step();

    // Slave never answers: only MaxOutstanding strobes get through
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    repeat (MAXO) step();
    check_val("t4_full_stall", m_stall[0], 1'b1);
    check_val("t4_full_stb", s_stb, 1'b0);
    step();
    m_stb[0] = 1'b0; m_cyc[0] = 1'b0; s_ack = 1'b1;
    repeat (MAXO) step();
    s_ack = 1'b0;
    check_val("t4_drained", s_cyc, 1'b0);
    step();

    // Error with two outstanding clears the count
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    step();
    step();
    m_stb[0] = 1'b0; s_err = 1'b1;
    #1;
    check_val("t5_err", m_err[0], 1'b1);
    step();
    s_err = 1'b0; m_cyc[0] = 1'b0;
    step();
    check_val("t5_rel", s_cyc, 1'b0);
    step();

    // Reset with three outstanding restores priority
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    repeat (3) step();
    reset = 1'b1; m_stb = '0;
    step();
    reset = 1'b0; m_cyc = '0;
    #1;
    check_val("t6_scyc", s_cyc, 1'b0);
    m_cyc = 3'b110;
    step();
    check_val("t6_own1", m_stall[1], 1'b0);
    check_val("t6_stall2", m_stall[2], 1'b1);
    m_cyc = '0;
    step();
    step();

    // Randomized traffic
    act = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            act[i]  = 1'b1;
            left[i] = $urandom_range(0, 5);
          end
        end else if (left[i] == 0 && $urandom_range(0, 1) == 0) begin
          act[i] = 1'b0;
        end
        m_cyc[i]    = act[i];
        m_stb[i]    = act[i] && (left[i] > 0);
        m_addr[i]   = $urandom;
        m_data_m[i] = $urandom;
        m_sel[i]    = SW'($urandom);
        m_we[i]     = 1'($urandom);
      end
      s_stall  = ($urandom_range(0, 3) == 0);
      s_ack    = (pend > 0) && ($urandom_range(0, 1) == 0);
      s_err    = (pend > 0) && ($urandom_range(0, 24) == 0);
      s_data_s = $urandom;
      reset    = ($urandom_range(0, 199) == 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (acc_vec[i] && left[i] > 0) left[i]--;
      end
    end
    reset = 1'b0;
    idle_inputs();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
